tapline_mc: RTL and testbench
=============================

# tapline_mc

Multi-channel, parametrised tap delay line for the filter IP. It keeps the last M samples of each of CHANNELS independent input streams in circular buffers, so no shift phase is needed. On each `start` it inserts the new sample into the selected channel and streams that channel's M taps, newest first, to a BRAM write port at a programmable enable rate. It sits between the sample acquisition front end and the FIR coefficient/MAC stage, which reads the taps from BRAM.

## Interface
- `M`, 4: taps per channel (≥2).
- `CHANNELS`, 2: independent channels (≥1).
- `CH_SIZE`, 1: width of `ch`; 2^CH_SIZE ≥ CHANNELS.
- `ADDR_SIZE`, 5: BRAM address width; CHANNELS*M ≤ 2^ADDR_SIZE.
- `DATA_SIZE`, 12: sample width.
- `EN_PERIOD`, 2: cycles per BRAM write (≥1).
- `clk` in 1: the only clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to insert `di` into channel `ch`.
- `ch` in CH_SIZE: channel select, sampled with `start`.
- `di` in DATA_SIZE: new sample.
- `addr` out ADDR_SIZE: BRAM address = ch*M + k, where k is the tap index (0 = newest).
- `do` out DATA_SIZE: tap data; 0 outside S_WRITE.
- `en` out 1: BRAM enable/write strobe.
- `done` out 1: 1-cycle pulse on the last write.
- `ready` out 1: 1-cycle pulse, the cycle after `done`.
- `busy` out 1: high when not in S_IDLE.
- `drop` out 1: 1-cycle pulse when `start` is rejected.

## Operation
- Storage: CHANNELS×M words plus one write pointer `wptr[c]` (0..M-1) per channel, pointing to the newest sample. Reset sets all words to 0 and all `wptr` to 0.
- FSM states:
  - S_IDLE: go to S_ADD on an accepted `start`.
  - S_ADD: go to S_WRITE.
  - S_WRITE: go to S_IDLE on `done`.
- An accepted `start` requires S_IDLE and `ch < CHANNELS`. In S_ADD, the block latches `ch`, sets `wptr[ch] ← (wptr[ch]+1) mod M`, writes `di` at the new pointer, and clears k and the phase counter.
- Rejected `start` (busy, or `ch ≥ CHANNELS`): `drop` is asserted combinationally in the same cycle. Storage, pointers and state are unchanged.
- S_WRITE:
  - The phase counter counts 0..EN_PERIOD-1 and wraps.
  - `en` = S_WRITE & (phase == EN_PERIOD-1).
  - `do` = buff[ch][(wptr[ch] − k) mod M] throughout S_WRITE.
  - k increments on each `en`.
- `done` = `en` & (k == M-1). `ready` is `done` registered.
- Pointer arithmetic: modulo M, with explicit wrap; M need not be a power of two.
- Other channels' data and pointers are never touched by a `start` on a different channel.

## Timing
- Reset values: `addr`=0, `do`=0, `en`=0, `done`=0, `ready`=0, `busy`=0, `drop`=0; state S_IDLE.
- `start` sampled at edge 0:
  - S_ADD in cycle 1.
  - S_WRITE from cycle 2.
  - First `en` in cycle 2+EN_PERIOD−1.
  - Last `en` and `done` in cycle 1+M*EN_PERIOD.
  - `ready` one cycle later, state S_IDLE.
- A new `start` is accepted in the `ready` cycle. Minimum start-to-start spacing is M*EN_PERIOD+2 cycles.
- `addr` is valid whenever `en` is high; it holds ch*M+k and is 0 in S_IDLE.
- `rst` mid-operation: back to S_IDLE with all outputs at reset values on the next cycle. Storage and pointers are cleared; no `done` or `ready` is issued.
- `start` is ignored in the same cycle as `rst`.

## Configuration
- `TAPLINE_FLUSH_EN` defined:
  - Adds input `flush` (1 bit).
  - `flush` in S_IDLE clears all storage and pointers of every channel in one cycle.
  - `flush` outside S_IDLE is ignored.
  - `flush` together with `start`: flush wins, `start` is rejected and `drop` pulses.
- `TAPLINE_FLUSH_EN` undefined: no `flush` port; storage is cleared only by `rst`.

## Test plan
All scenarios use M=4, CHANNELS=2, EN_PERIOD=2.
- Reset, then `start` ch0 with di=0x111: four `en` pulses, 2 cycles apart, first in cycle 3. `addr` 0,1,2,3; `do` 0x111,0,0,0. `done` on the 4th `en` (cycle 9), `ready` in cycle 10.
- Five sequential starts on ch0 with di=1..5 (wrap): the final burst gives `do` 5,4,3,2 at `addr` 0..3.
- Starts ch0 0xA, then ch1 0xB, then ch0 0xC:
  - ch1 burst: `addr` 4..7, `do` 0xB,0,0,0.
  - Third burst: `addr` 0..3, `do` 0xC,0xA,0,0.
- `start` while busy, and separately `start` with ch=2 (CH_SIZE=2 build): `drop`=1 for one cycle, no burst, later bursts unaffected.
- `rst` pulsed in the second `en` of a burst: outputs 0 next cycle, no `done`. Next start di=0x7 gives `do` 7,0,0,0.
- `TAPLINE_FLUSH_EN` build: fill ch0 with 1..3, then `flush` in S_IDLE, then start di=9: `do` 9,0,0,0. `flush` and `start` in the same cycle: `drop`=1.

Source files
------------

// File: rtl/tapline_mc_if.sv
// Bus bundle for the tapline_mc tap delay line: sample request side plus BRAM write side.
// With TAPLINE_FLUSH_EN defined the bundle also carries the flush request.
interface tapline_mc_if #(
  parameter int CH_SIZE   = 1,
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 12
);
  logic                 start;
  logic [CH_SIZE-1:0]   ch;
  logic [DATA_SIZE-1:0] di;
`ifdef TAPLINE_FLUSH_EN
  logic                 flush;
`endif
  logic [ADDR_SIZE-1:0] addr;
  // tap data output; "do" is a reserved word, hence dout
  logic [DATA_SIZE-1:0] dout;
  logic                 en;
  logic                 done;
  logic                 ready;
  logic                 busy;
  logic                 drop;

  modport master (
`ifdef TAPLINE_FLUSH_EN
    output flush,
`endif
    output start, ch, di,
    input  addr, dout, en, done, ready, busy, drop
  );

  modport slave (
`ifdef TAPLINE_FLUSH_EN
    input  flush,
`endif
    input  start, ch, di,
    output addr, dout, en, done, ready, busy, drop
  );
endinterface

// File: rtl/tapline_mc.sv
// Multi-channel circular tap delay line streaming M taps per start to a BRAM write port.
// Optional TAPLINE_FLUSH_EN adds a one-cycle clear of all channels while idle.
module tapline_mc #(
  parameter int M         = 4,
  parameter int CHANNELS  = 2,
  parameter int CH_SIZE   = 1,
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 12,
  parameter int EN_PERIOD = 2
) (
  input logic         clk,
  input logic         rst,
  tapline_mc_if.slave bus
);
  localparam int PTR_W  = $clog2(M);
  localparam int CIDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PH_W   = (EN_PERIOD > 1) ? $clog2(EN_PERIOD) : 1;
  localparam logic [CH_SIZE:0] CH_LIMIT = (CH_SIZE+1)'(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_WRITE} state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] buff [CHANNELS][M];
  logic [PTR_W-1:0]     wptr [CHANNELS];
  logic [CIDX_W-1:0]    ch_q;
  logic [DATA_SIZE-1:0] di_q;
  logic [PTR_W-1:0]     k;
  logic [PH_W-1:0]      phase;
  logic                 ready_q;

  logic             ch_ok, flush_req, accept, clear_all, en_int, done_int;
  logic [PTR_W-1:0] cur_ptr, nxt_ptr, rd_idx;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
`ifdef TAPLINE_FLUSH_EN
    flush_req = bus.flush;
`else
    flush_req = 1'b0;
`endif
    ch_ok     = ({1'b0, bus.ch} < CH_LIMIT);
    accept    = bus.start & ~rst & (state_q == S_IDLE) & ch_ok & ~flush_req;
    clear_all = rst | (flush_req & (state_q == S_IDLE));
    cur_ptr   = wptr[ch_q];
    nxt_ptr   = (cur_ptr == PTR_W'(M-1)) ? '0 : cur_ptr + 1'b1;
    // explicit wrap keeps the read index correct for non-power-of-two M
    if (cur_ptr >= k) rd_idx = cur_ptr - k;
    else              rd_idx = PTR_W'({1'b0, cur_ptr} + (PTR_W+1)'(M) - {1'b0, k});
    en_int    = (state_q == S_WRITE) && (phase == PH_W'(EN_PERIOD-1));
    done_int  = en_int && (k == PTR_W'(M-1));

    bus.en    = en_int;
    bus.done  = done_int;
    bus.ready = ready_q;
    bus.busy  = (state_q != S_IDLE);
    bus.drop  = bus.start & ~rst & ((state_q != S_IDLE) | ~ch_ok | flush_req);
    bus.addr  = '0;
    bus.dout  = '0;
    if (state_q == S_WRITE) begin
      bus.addr = ADDR_SIZE'(ch_q) * ADDR_SIZE'(M) + ADDR_SIZE'(k);
      bus.dout = buff[ch_q][rd_idx];
    end

    case (state_q)
      S_IDLE:  if (accept) state_d = S_ADD;
      S_ADD:   state_d = S_WRITE;
      S_WRITE: if (done_int) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The new sample lands at the advanced pointer, so the newest tap is always at wptr.
  always_ff @(posedge clk) begin
    if (clear_all) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < M; t++) buff[c][t] <= '0;
      end
    end else if (state_q == S_ADD) begin
      wptr[ch_q]          <= nxt_ptr;
      buff[ch_q][nxt_ptr] <= di_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      di_q    <= '0;
      k       <= '0;
      phase   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= done_int;
      if (accept) begin
        ch_q <= bus.ch[CIDX_W-1:0];
        di_q <= bus.di;
      end
      if (state_q == S_ADD) begin
        k     <= '0;
        phase <= '0;
      end else if (state_q == S_WRITE) begin
        phase <= (phase == PH_W'(EN_PERIOD-1)) ? '0 : phase + 1'b1;
        if (en_int) k <= k + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tapline_mc.sv
// Directed bench for tapline_mc: table of bursts with hand-computed taps plus corner sequences.
// Flush scenarios run only when TAPLINE_FLUSH_EN is defined.
module tb_tapline_mc;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  tapline_mc_if #(.CH_SIZE(2), .ADDR_SIZE(5), .DATA_SIZE(12)) bus ();

  tapline_mc #(
    .M(4), .CHANNELS(2), .CH_SIZE(2), .ADDR_SIZE(5), .DATA_SIZE(12), .EN_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst_first;
    logic [1:0]       ch;
    logic [11:0]      di;
    logic [3:0][11:0] exp_taps;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkVec(input logic r, input logic [1:0] c, input logic [11:0] d,
                                 input logic [11:0] e0, input logic [11:0] e1,
                                 input logic [11:0] e2, input logic [11:0] e3);
    vec_t v;
    v.rst_first   = r;
    v.ch          = c;
    v.di          = d;
    v.exp_taps[0] = e0;
    v.exp_taps[1] = e1;
    v.exp_taps[2] = e2;
    v.exp_taps[3] = e3;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Returns just after a negedge with reset released.
  task automatic doReset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.ch    = 2'd0;
    bus.di    = 12'hFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset addr", 32'(bus.addr), 0);
    checkOutput("reset do", 32'(bus.dout), 0);
    checkOutput("reset en", 32'(bus.en), 0);
    checkOutput("reset done", 32'(bus.done), 0);
    checkOutput("reset ready", 32'(bus.ready), 0);
    checkOutput("reset busy", 32'(bus.busy), 0);
    checkOutput("reset drop", 32'(bus.drop), 0);
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  // Issues a start at the current negedge (cycle 0) and checks cycles 1..10 of the burst.
  task automatic applyStimulus(input logic [1:0] c, input logic [11:0] d,
                               input logic [3:0][11:0] e, input string tag);
    int   k;
    logic exp_en;
    k         = 0;
    bus.start = 1'b1;
    bus.ch    = c;
    bus.di    = d;
    #1;
    checkOutput({tag, " drop"}, 32'(bus.drop), 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      exp_en = (cyc >= 3) && (cyc <= 9) && (cyc % 2 == 1);
      checkOutput($sformatf("%s en c%0d", tag, cyc), 32'(bus.en), 32'(exp_en));
      if (exp_en && bus.en && k < 4) begin
        checkOutput($sformatf("%s addr k%0d", tag, k), 32'(bus.addr), 32'(c) * 4 + k);
        checkOutput($sformatf("%s do k%0d", tag, k), 32'(bus.dout), 32'(e[k]));
        k++;
      end
      checkOutput($sformatf("%s done c%0d", tag, cyc), 32'(bus.done), 32'(cyc == 9));
      checkOutput($sformatf("%s ready c%0d", tag, cyc), 32'(bus.ready), 32'(cyc == 10));
      checkOutput($sformatf("%s busy c%0d", tag, cyc), 32'(bus.busy), 32'(cyc < 10));
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit got_ready;
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.ch    = '0;
    bus.di    = '0;
`ifdef TAPLINE_FLUSH_EN
    bus.flush = 1'b0;
`endif

    vecs[0] = mkVec(1'b1, 2'd0, 12'h111, 12'h111, 12'h000, 12'h000, 12'h000);
    vecs[1] = mkVec(1'b0, 2'd0, 12'h001, 12'h001, 12'h111, 12'h000, 12'h000);
    vecs[2] = mkVec(1'b0, 2'd0, 12'h002, 12'h002, 12'h001, 12'h111, 12'h000);
    vecs[3] = mkVec(1'b0, 2'd0, 12'h003, 12'h003, 12'h002, 12'h001, 12'h111);
    vecs[4] = mkVec(1'b0, 2'd0, 12'h004, 12'h004, 12'h003, 12'h002, 12'h001);
    vecs[5] = mkVec(1'b0, 2'd0, 12'h005, 12'h005, 12'h004, 12'h003, 12'h002);
    vecs[6] = mkVec(1'b1, 2'd0, 12'h00A, 12'h00A, 12'h000, 12'h000, 12'h000);
    vecs[7] = mkVec(1'b0, 2'd1, 12'h00B, 12'h00B, 12'h000, 12'h000, 12'h000);
    vecs[8] = mkVec(1'b0, 2'd0, 12'h00C, 12'h00C, 12'h00A, 12'h000, 12'h000);
    vecs[9] = mkVec(1'b0, 2'd1, 12'h00D, 12'h00D, 12'h00B, 12'h000, 12'h000);

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_first) doReset();
      applyStimulus(vecs[i].ch, vecs[i].di, vecs[i].exp_taps, $sformatf("vec%0d", i));
    end

    // start while busy is dropped and leaves ch1 untouched
    doReset();
    bus.start = 1'b1; bus.ch = 2'd0; bus.di = 12'h021;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.ch = 2'd1; bus.di = 12'h055;
    #1;
    checkOutput("busy drop", 32'(bus.drop), 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    #1;
    checkOutput("busy drop clears", 32'(bus.drop), 0);
    got_ready = 1'b0;
    for (int i = 0; i < 20 && !got_ready; i++) begin
      @(negedge clk);
      if (bus.ready) got_ready = 1'b1;
    end
    checkOutput("busy burst ready", 32'(got_ready), 1);
    applyStimulus(2'd1, 12'h066, {12'h000, 12'h000, 12'h000, 12'h066}, "after_busy_ch1");
    applyStimulus(2'd0, 12'h022, {12'h000, 12'h000, 12'h021, 12'h022}, "after_busy_ch0");

    // out-of-range channel
    bus.start = 1'b1; bus.ch = 2'd2; bus.di = 12'h077;
    #1;
    checkOutput("bad ch drop", 32'(bus.drop), 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checkOutput("bad ch busy", 32'(bus.busy), 0);
    checkOutput("bad ch drop clears", 32'(bus.drop), 0);
    applyStimulus(2'd1, 12'h088, {12'h000, 12'h000, 12'h066, 12'h088}, "after_bad_ch");

    // reset during the second en of a burst
    doReset();
    bus.start = 1'b1; bus.ch = 2'd0; bus.di = 12'h031;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid rst second en", 32'(bus.en), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid rst en", 32'(bus.en), 0);
    checkOutput("mid rst addr", 32'(bus.addr), 0);
    checkOutput("mid rst do", 32'(bus.dout), 0);
    checkOutput("mid rst busy", 32'(bus.busy), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mid rst no done %0d", i), 32'(bus.done | bus.ready), 0);
    end
    applyStimulus(2'd0, 12'h007, {12'h000, 12'h000, 12'h000, 12'h007}, "after_mid_rst");

`ifdef TAPLINE_FLUSH_EN
    doReset();
    applyStimulus(2'd0, 12'h001, {12'h000, 12'h000, 12'h000, 12'h001}, "fill1");
    applyStimulus(2'd0, 12'h002, {12'h000, 12'h000, 12'h001, 12'h002}, "fill2");
    applyStimulus(2'd0, 12'h003, {12'h000, 12'h001, 12'h002, 12'h003}, "fill3");
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    applyStimulus(2'd0, 12'h009, {12'h000, 12'h000, 12'h000, 12'h009}, "after_flush");
    bus.flush = 1'b1; bus.start = 1'b1; bus.ch = 2'd0; bus.di = 12'h005;
    #1;
    checkOutput("flush+start drop", 32'(bus.drop), 1);
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.start = 1'b0; end
    @(negedge clk);
    checkOutput("flush+start busy", 32'(bus.busy), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
